// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction fetch block and the CPU top that hosts it.
// Holds the FSM encoding and the default program depth and NOP word.
package insn_fetch_pkg;
  localparam int         DEPTH_DEFAULT = 16;
  localparam int         INSN_W        = 6;
  localparam logic [5:0] NOP_DEFAULT   = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;
endpackage

// File: rtl/insn_fetch_mem.sv
// Program store: DEPTH x W register array with one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module insn_mem #(
  parameter  int DEPTH = 16,
  parameter  int W     = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/insn_fetch.sv
// Loads a short program through a valid/ready port, then holds the CPU in reset
// for one BOOT cycle and serves instructions combinationally from the CPU's pc.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter  int         DEPTH    = DEPTH_DEFAULT,
  parameter  logic [5:0] NOP_INSN = NOP_DEFAULT,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         LW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [5:0]    load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic          clear,
  input  logic [7:0]    pc,
  output logic [5:0]    insn,
  output logic          cpu_rst,
  output logic [LW-1:0] prog_len,
  output logic          halted,
  output state_t        fsm_state
);
  // Handshake: a word transfers on any rising edge where load_valid && load_ready;
  // load_ready never depends on load_valid, and a transfer in a rst cycle is dropped.
  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          accept, in_range, we;
  logic [5:0]    rd;

  assign load_ready = (state_q == ST_IDLE) && (len_q != LW'(DEPTH)) && !clear;
  assign accept     = load_valid && load_ready;
  assign we         = accept && !rst;
  // Full-width compare so pc values above the array never alias into it.
  assign in_range   = 32'(pc) < 32'(len_q);

  insn_mem #(.DEPTH(DEPTH), .W(6)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (len_q[AW-1:0]),
    .wdata (load_data),
    .raddr (pc[AW-1:0]),
    .rdata (rd)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (accept) len_d = len_q + LW'(1);
    case (state_q)
      ST_IDLE: begin
        if (clear) len_d = '0;
        else if (start && ((len_q != '0) || accept)) state_d = ST_BOOT;
      end
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!in_range) state_d = ST_HALT;
      ST_HALT: begin
        if (clear) begin
          state_d = ST_IDLE;
          len_d   = '0;
        end else if (start) begin
          state_d = ST_BOOT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign cpu_rst   = (state_q == ST_IDLE) || (state_q == ST_BOOT);
  assign halted    = (state_q == ST_HALT);
  assign insn      = ((state_q == ST_RUN) && in_range) ? rd : NOP_INSN;
  assign prog_len  = len_q;
  assign fsm_state = state_q;
endmodule
